// File: rtl/hd44780_pkg.sv
// Shared types, init ROM and helpers for the HD44780 4-bit write-only sequencer.
package hd44780_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT_NIB,
        ST_INIT_WAIT,
        ST_IDLE,
        ST_XFER,
        ST_EXEC
    } state_e;

    typedef enum logic [1:0] {
        W_4100,
        W_100,
        W_EXEC,
        W_BYTE
    } wsel_e;

    typedef struct packed {
        logic       is_byte;
        logic [7:0] val;
        wsel_e      wsel;
    } init_ent_t;

    localparam int INIT_LEN      = 9;
    localparam int INIT_WAIT1_US = 4100;
    localparam int INIT_WAIT2_US = 100;

    function automatic init_ent_t init_rom(input logic [3:0] idx);
        init_ent_t e;
        e = '{1'b0, 8'h00, W_EXEC};
        case (idx)
            4'd0: e = '{1'b0, 8'h03, W_4100};
            4'd1: e = '{1'b0, 8'h03, W_100};
            4'd2: e = '{1'b0, 8'h03, W_EXEC};
            4'd3: e = '{1'b0, 8'h02, W_EXEC};
            4'd4: e = '{1'b1, 8'h28, W_BYTE};
            4'd5: e = '{1'b1, 8'h08, W_BYTE};
            4'd6: e = '{1'b1, 8'h01, W_BYTE};
            4'd7: e = '{1'b1, 8'h06, W_BYTE};
            4'd8: e = '{1'b1, 8'h0C, W_BYTE};
            default: e = '{1'b0, 8'h00, W_EXEC};
        endcase
        return e;
    endfunction

    // Clear and return-home need the long execution time.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] dat);
        return !rs && (dat[7:2] == 6'd0);
    endfunction

    function automatic logic [3:0] first_nib(input init_ent_t e);
        return e.is_byte ? e.val[7:4] : e.val[3:0];
    endfunction

endpackage

// File: rtl/hd44780_nibble_tx.sv
// One E-strobed nibble: RS/DB set up, E high, E low, then a done pulse.
module hd44780_nibble_tx
    import hd44780_pkg::*;
#(
    parameter int E_SETUP_CYC = 1,
    parameter int E_HIGH_CYC  = 6,
    parameter int E_LOW_CYC   = 6
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [3:0] nib_i,
    input  logic       rs_i,
    output logic       lcd_e_o,
    output logic [3:0] lcd_db_o,
    output logic       lcd_rs_o,
    output logic       done_o
);

    localparam int TOT = E_SETUP_CYC + E_HIGH_CYC + E_LOW_CYC;
    localparam int CW  = $clog2(TOT + 1);
    localparam logic [CW-1:0] LAST = CW'(TOT - 1);

    logic          busy_q, busy_d;
    logic          e_q, e_d;
    logic          rs_q, rs_d;
    logic [3:0]    db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic e_at(input logic [CW-1:0] c);
        return (int'(c) >= E_SETUP_CYC) &&
               (int'(c) < E_SETUP_CYC + E_HIGH_CYC);
    endfunction

    assign done_o   = busy_q && (cnt_q == LAST);
    assign lcd_e_o  = e_q;
    assign lcd_db_o = db_q;
    assign lcd_rs_o = rs_q;

    // A start on the done cycle chains the next nibble with no gap.
    always_comb begin
        busy_d = busy_q;
        e_d    = e_q;
        rs_d   = rs_q;
        db_d   = db_q;
        cnt_d  = cnt_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            rs_d   = rs_i;
            db_d   = nib_i;
            e_d    = e_at('0);
        end else if (busy_q) begin
            if (done_o) begin
                busy_d = 1'b0;
                e_d    = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                e_d   = e_at(cnt_q + 1'b1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            e_q    <= 1'b0;
            rs_q   <= 1'b0;
            db_q   <= 4'h0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            e_q    <= e_d;
            rs_q   <= rs_d;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/hd44780_ctrl.sv
// HD44780 4-bit write-only sequencer: power-up init, then STB/ACK byte writes
// with open-loop execution waits.
module hd44780_ctrl
    import hd44780_pkg::*;
#(
    parameter int TICKS_PER_US = 12,
    parameter int E_SETUP_CYC  = 1,
    parameter int E_HIGH_CYC   = 6,
    parameter int E_LOW_CYC    = 6,
    parameter int POWERUP_US   = 40000,
    parameter int EXEC_US      = 40,
    parameter int EXEC_LONG_US = 1600
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic [7:0] DAT_I,
    input  logic       RS_I,
    input  logic       STB_I,
    output logic       ACK_O,
    output logic       READY_O,
    output logic       BUSY_O,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [3:0] LCD_DB
);

    localparam int MAX_A = (POWERUP_US > INIT_WAIT1_US) ? POWERUP_US : INIT_WAIT1_US;
    localparam int MAX_US = (MAX_A > EXEC_LONG_US) ? MAX_A : EXEC_LONG_US;
    localparam int WW = $clog2(MAX_US + 1);
    localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

    localparam logic [WW-1:0] PWRUP_W = WW'(POWERUP_US);
    localparam logic [WW-1:0] W1_W    = WW'(INIT_WAIT1_US);
    localparam logic [WW-1:0] W2_W    = WW'(INIT_WAIT2_US);
    localparam logic [WW-1:0] EXEC_W  = WW'(EXEC_US);
    localparam logic [WW-1:0] LONG_W  = WW'(EXEC_LONG_US);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_US - 1);

    state_e        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic          lo_q, lo_d;
    logic [7:0]    byte_q, byte_d;
    logic          rs_q, rs_d;
    logic          ready_q, ready_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [PW-1:0] pre_q, pre_d;

    logic          wload;
    logic [WW-1:0] wval;
    logic          wait_last;
    logic          tx_start, tx_rs, tx_done;
    logic [3:0]    tx_nib;
    logic          ack;
    init_ent_t     ent, nxt;

    assign ent       = init_rom(idx_q);
    assign nxt       = init_rom(idx_q + 4'd1);
    assign wait_last = (wcnt_q <= WW'(1)) && (pre_q == PRE_LAST);

    assign ACK_O   = ack;
    assign READY_O = ready_q;
    assign BUSY_O  = !(state_q == ST_IDLE && ready_q);
    assign LCD_RW  = 1'b0;

    function automatic logic [WW-1:0] init_wait(input init_ent_t e);
        logic [WW-1:0] w;
        w = EXEC_W;
        case (e.wsel)
            W_4100:  w = W1_W;
            W_100:   w = W2_W;
            W_EXEC:  w = EXEC_W;
            W_BYTE:  w = is_long_cmd(1'b0, e.val) ? LONG_W : EXEC_W;
            default: w = EXEC_W;
        endcase
        return w;
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        lo_d     = lo_q;
        byte_d   = byte_q;
        rs_d     = rs_q;
        ready_d  = ready_q;
        tx_start = 1'b0;
        tx_nib   = 4'h0;
        tx_rs    = 1'b0;
        wload    = 1'b0;
        wval     = '0;
        ack      = 1'b0;
        unique case (state_q)
            ST_PWRUP: begin
                if (wait_last) begin
                    tx_start = 1'b1;
                    tx_nib   = first_nib(ent);
                    lo_d     = 1'b0;
                    state_d  = ST_INIT_NIB;
                end
            end
            ST_INIT_NIB: begin
                if (tx_done) begin
                    if (ent.is_byte && !lo_q) begin
                        tx_start = 1'b1;
                        tx_nib   = ent.val[3:0];
                        lo_d     = 1'b1;
                    end else begin
                        wload   = 1'b1;
                        wval    = init_wait(ent);
                        state_d = ST_INIT_WAIT;
                    end
                end
            end
            ST_INIT_WAIT: begin
                if (wait_last) begin
                    if (idx_q == 4'(INIT_LEN - 1)) begin
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d    = idx_q + 4'd1;
                        tx_start = 1'b1;
                        tx_nib   = first_nib(nxt);
                        lo_d     = 1'b0;
                        state_d  = ST_INIT_NIB;
                    end
                end
            end
            ST_IDLE: begin
                if (STB_I && ready_q) begin
                    byte_d   = DAT_I;
                    rs_d     = RS_I;
                    tx_start = 1'b1;
                    tx_nib   = DAT_I[7:4];
                    tx_rs    = RS_I;
                    lo_d     = 1'b0;
                    state_d  = ST_XFER;
                end
            end
            ST_XFER: begin
                if (tx_done) begin
                    if (!lo_q) begin
                        tx_start = 1'b1;
                        tx_nib   = byte_q[3:0];
                        tx_rs    = rs_q;
                        lo_d     = 1'b1;
                    end else begin
                        wload   = 1'b1;
                        wval    = is_long_cmd(rs_q, byte_q) ? LONG_W : EXEC_W;
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (wait_last) begin
                    ack     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_PWRUP;
        endcase
    end

    // Prescaled microsecond down-counter; it saturates at zero.
    always_comb begin
        wcnt_d = wcnt_q;
        pre_d  = pre_q;
        if (wload) begin
            wcnt_d = wval;
            pre_d  = '0;
        end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (wcnt_q != '0) wcnt_d = wcnt_q - 1'b1;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= ST_PWRUP;
            idx_q   <= 4'd0;
            lo_q    <= 1'b0;
            byte_q  <= 8'h00;
            rs_q    <= 1'b0;
            ready_q <= 1'b0;
            wcnt_q  <= PWRUP_W;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            byte_q  <= byte_d;
            rs_q    <= rs_d;
            ready_q <= ready_d;
            wcnt_q  <= wcnt_d;
            pre_q   <= pre_d;
        end
    end

    hd44780_nibble_tx #(
        .E_SETUP_CYC (E_SETUP_CYC),
        .E_HIGH_CYC  (E_HIGH_CYC),
        .E_LOW_CYC   (E_LOW_CYC)
    ) u_tx (
        .clk_i    (CLK_I),
        .rst_i    (RST_I),
        .start_i  (tx_start),
        .nib_i    (tx_nib),
        .rs_i     (tx_rs),
        .lcd_e_o  (LCD_E),
        .lcd_db_o (LCD_DB),
        .lcd_rs_o (LCD_RS),
        .done_o   (tx_done)
    );

endmodule
